// File: rtl/positional_decoding.sv
// Streaming positional-table removal: out = in - pos[token*E + dim], one element per cycle.
// Optional clamping of out-of-range results is enabled by defining POSITIONAL_DECODING_SAT_EN.
module positional_decoding #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TOKENS = 196,
    parameter int E          = 128,
    localparam int TOTAL     = NUM_TOKENS * E,
    localparam int AW        = $clog2(TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pos_rd_en,
    output logic [AW-1:0]         pos_rd_addr,
    input  logic [DATA_WIDTH-1:0] pos_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counters carry one extra bit so that TOTAL itself is representable.
    localparam logic [AW:0] TOTAL_C = (AW+1)'(TOTAL);
    localparam logic [AW:0] LAST_C  = (AW+1)'(TOTAL - 1);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    busy_r;
    logic                    done_r;
    logic [AW:0]             in_idx_r;
    logic [AW:0]             out_idx_r;
    logic                    a_valid_r;
    logic                    a_pend_r;
    logic [DATA_WIDTH-1:0]   a_data_r;
    logic [DATA_WIDTH-1:0]   a_pos_r;
    logic                    out_valid_r;
    logic                    out_last_r;
    logic [DATA_WIDTH-1:0]   out_data_r;

    logic                    start_go_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    load_s;
    logic                    out_hs_s;
    logic                    last_hs_s;
    logic [DATA_WIDTH-1:0]   pos_s;
    logic [DATA_WIDTH-1:0]   res_s;
    logic                    ovf_s;

`ifdef POSITIONAL_DECODING_SAT_EN
    function automatic logic [DATA_WIDTH:0] sub_ext(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    endfunction

    function automatic logic ovf_chk(input logic [DATA_WIDTH:0] d);
        return d[DATA_WIDTH] ^ d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_val(input logic [DATA_WIDTH:0] d);
        logic [DATA_WIDTH-1:0] r;
        if (ovf_chk(d)) begin
            r = d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            r = d[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [DATA_WIDTH:0] diff_s;
    assign diff_s = sub_ext(a_data_r, pos_s);
    assign res_s  = sat_val(diff_s);
    assign ovf_s  = ovf_chk(diff_s);
`else
    assign res_s  = a_data_r - pos_s;
    assign ovf_s  = 1'b0;
`endif

    // Handshake and datapath steering.
    always_comb begin
        start_go_s = (state_r == S_IDLE) && start;
        load_s     = a_valid_r && (!out_valid_r || out_ready);
        in_ready_s = (state_r == S_RUN) && (in_idx_r < TOTAL_C) && (!a_valid_r || load_s);
        accept_s   = in_ready_s && in_valid;
        out_hs_s   = out_valid_r && out_ready;
        last_hs_s  = out_hs_s && out_last_r;
        // Table data is on the bus only the cycle after the read; later it comes from A.
        if (a_pend_r) begin
            pos_s = pos_rd_data;
        end else begin
            pos_s = a_pos_r;
        end
    end

    // Frame sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_hs_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register with registered status decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Input counter doubles as the table read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx_r <= '0;
        end else if (start_go_s) begin
            in_idx_r <= '0;
        end else if (accept_s) begin
            in_idx_r <= in_idx_r + ONE_C;
        end
    end

    // Hold slot A: element captured at accept, table word captured if the output stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_r <= 1'b0;
            a_pend_r  <= 1'b0;
            a_data_r  <= '0;
            a_pos_r   <= '0;
        end else if (start_go_s) begin
            a_valid_r <= 1'b0;
            a_pend_r  <= 1'b0;
        end else if (accept_s) begin
            a_valid_r <= 1'b1;
            a_pend_r  <= 1'b1;
            a_data_r  <= in_data;
        end else if (load_s) begin
            a_valid_r <= 1'b0;
            a_pend_r  <= 1'b0;
        end else if (a_pend_r) begin
            a_pos_r   <= pos_rd_data;
            a_pend_r  <= 1'b0;
        end
    end

    // Output register and element counter; contents frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
        end else if (start_go_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_idx_r   <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= res_s;
            out_last_r  <= (out_idx_r == LAST_C);
            out_idx_r   <= out_idx_r + ONE_C;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

`ifdef POSITIONAL_DECODING_SAT_EN
    logic sat_r;

    // Sticky saturation indicator, cleared when a frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (start_go_s) begin
            sat_r <= 1'b0;
        end else if (load_s && ovf_s) begin
            sat_r <= 1'b1;
        end
    end

    assign sat_flag = sat_r;
`else
    assign sat_flag = 1'b0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign in_ready    = in_ready_s;
    assign pos_rd_en   = accept_s;
    assign pos_rd_addr = in_idx_r[AW-1:0];
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;

endmodule

// File: tb/tb_positional_decoding.sv
// Randomized self-checking bench for positional_decoding with a queue-based reference model.
module tb_positional_decoding;
    localparam int DW    = 16;
    localparam int NT    = 2;
    localparam int EE    = 3;
    localparam int TOTAL = NT * EE;
    localparam int AW    = $clog2(TOTAL);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          pos_rd_en;
    logic [AW-1:0] pos_rd_addr;
    logic [DW-1:0] pos_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          sat_flag;

    always #5 clk = ~clk;

    positional_decoding #(.DATA_WIDTH(DW), .NUM_TOKENS(NT), .E(EE)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pos_rd_en(pos_rd_en), .pos_rd_addr(pos_rd_addr), .pos_rd_data(pos_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    // Positional table RAM: one-cycle read latency, garbage on the bus otherwise.
    logic [DW-1:0] pos_mem [0:7];
    always @(posedge clk) begin
        pos_rd_data <= pos_rd_en ? pos_mem[pos_rd_addr] : 16'($urandom);
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_val(input logic [DW-1:0] x, input logic [DW-1:0] p,
                                                 output bit ov);
        int xi;
        int pi;
        int r;
        xi = $signed(x);
        pi = $signed(p);
        r  = xi - pi;
        ov = (r > 32767) || (r < -32768);
`ifdef POSITIONAL_DECODING_SAT_EN
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        return r[15:0];
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] obs_q [$];
    int            phase = 0;
    int            acc_cnt = 0;
    int            rd_cnt = 0;
    int            cyc = 0;
    int            first_acc_cyc = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;
    bit            seen_out = 1'b0;
    bit            run_first = 1'b0;
    bit            sat_exp = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // Reference model and compare process: phase 0 idle, 1 run, 2 done.
    always @(negedge clk) begin
        int   nxt;
        bit   ov;
        bit   sat_want;
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            phase      = 0;
            acc_cnt    = 0;
            rd_cnt     = 0;
            prev_stall = 1'b0;
            run_first  = 1'b0;
        end else begin
            nxt = phase;
            chk("busy", busy, phase == 1);
            chk("done", done, phase == 2);
            if (phase != 1) chk("in_ready_not_run", in_ready, 1'b0);
            if (phase == 1 && run_first) chk("in_ready_first", in_ready, 1'b1);
            if (phase == 1 && acc_cnt == TOTAL) chk("in_ready_full", in_ready, 1'b0);
            run_first = 1'b0;
            chk("rd_en", pos_rd_en, in_valid && in_ready);
            if (pos_rd_en) begin
                chk("rd_addr", pos_rd_addr, acc_cnt);
                rd_cnt++;
            end
            if (in_valid && in_ready) begin
                e.d = model_val(in_data, (acc_cnt < TOTAL) ? pos_mem[acc_cnt] : 16'h0000, ov);
                e.l = (acc_cnt == TOTAL - 1);
                exp_q.push_back(e);
                if (ov) sat_exp = 1'b1;
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && !seen_out) begin
                chk("first_latency", cyc - first_acc_cyc, 2);
                seen_out = 1'b1;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                    if (e.l) begin
                        nxt = 2;
`ifdef POSITIONAL_DECODING_SAT_EN
                        sat_want = sat_exp;
`else
                        sat_want = 1'b0;
`endif
                        chk("rd_count", rd_cnt, TOTAL);
                        chk("sat_flag", sat_flag, sat_want);
                        done_cyc = cyc + 1;
                    end
                end
            end
            case (phase)
                0: if (start) begin
                    nxt       = 1;
                    acc_cnt   = 0;
                    rd_cnt    = 0;
                    sat_exp   = 1'b0;
                    seen_out  = 1'b0;
                    run_first = 1'b1;
                    start_cyc = cyc;
                    exp_q.delete();
                end
                2: nxt = 0;
                default: ;
            endcase
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            phase      = nxt;
        end
    end

    logic [DW-1:0] vals [0:5];

    task automatic check_reset_outs();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_pos_rd_en", pos_rd_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_sat_flag", sat_flag, 1'b0);
        chk("rst_pos_rd_addr", pos_rd_addr, 0);
        chk("rst_out_data", out_data, 0);
    endtask

    // mode: 0 steady, 1 output stall window, 2 input bubbles, 3 random handshakes.
    task automatic frame(input int mode, input bit pulse_mid, input int abort_after,
                         input bit chain, input bit skip_start);
        int sent = 0;
        int n    = 0;
        int w    = 0;
        bit acc  = 1'b0;
        obs_q.delete();
        if (!skip_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        while (sent < TOTAL && n < 400) begin
            if (!in_valid || acc) begin
                case (mode)
                    2:       in_valid = (n % 2 == 0);
                    3:       in_valid = ($urandom_range(0, 3) != 0);
                    default: in_valid = 1'b1;
                endcase
                in_data = vals[sent];
            end
            case (mode)
                1:       out_ready = !(n >= 3 && n < 8);
                3:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            start = pulse_mid && (n == 3);
            @(negedge clk); #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
            if (abort_after > 0 && obs_q.size() >= abort_after) break;
            @(posedge clk); #1;
            n++;
        end
        if (abort_after > 0) begin
            @(posedge clk); #1;
            rst      = 1'b1;
            in_valid = 1'b0;
            start    = 1'b0;
            #1;
            check_reset_outs();
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout actual=%0d required=%0d", sent, TOTAL);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = chain;
        while (w < 300) begin
            @(negedge clk); #1;
            if (done) break;
            @(posedge clk); #1;
            out_ready = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            start     = chain;
            w++;
        end
        if (w >= 300) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        if (chain) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic set_basic();
        for (int i = 0; i < 8; i++) pos_mem[i] = 16'(i);
        for (int i = 0; i < TOTAL; i++) vals[i] = 16'(100 + i);
    endtask

    task automatic set_random();
        for (int i = 0; i < 8; i++) pos_mem[i] = 16'($urandom);
        for (int i = 0; i < TOTAL; i++) vals[i] = 16'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        set_basic();
        #1;
        check_reset_outs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame with hand-computed results.
        set_basic();
        frame(0, 1'b0, 0, 1'b0, 1'b0);
        chk("basic_count", obs_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("basic_value", (obs_q.size() > i) ? obs_q[i] : 16'hDEAD, 16'd100);
        chk("basic_done_cycle", done_cyc - start_cyc, 9);
        chk("basic_sat", sat_flag, 1'b0);

        set_random();
        frame(1, 1'b0, 0, 1'b0, 1'b0);
        set_random();
        frame(2, 1'b0, 0, 1'b0, 1'b0);

        // Overflow corners: 0x7FFF-(-1), 0x8000-1, 0-(-32768), -1-32767.
        pos_mem[0] = 16'hFFFF; pos_mem[1] = 16'h0003; pos_mem[2] = 16'h0001;
        pos_mem[3] = 16'h0000; pos_mem[4] = 16'h8000; pos_mem[5] = 16'h7FFF;
        vals[0] = 16'h7FFF; vals[1] = 16'h0005; vals[2] = 16'h8000;
        vals[3] = 16'h1234; vals[4] = 16'h0000; vals[5] = 16'hFFFF;
        frame(0, 1'b0, 0, 1'b0, 1'b0);
`ifdef POSITIONAL_DECODING_SAT_EN
        chk("ovf_pos", (obs_q.size() > 0) ? obs_q[0] : 16'hDEAD, 16'h7FFF);
        chk("ovf_neg", (obs_q.size() > 2) ? obs_q[2] : 16'hDEAD, 16'h8000);
        chk("ovf_sat_flag", sat_flag, 1'b1);
`else
        chk("ovf_pos", (obs_q.size() > 0) ? obs_q[0] : 16'hDEAD, 16'h8000);
        chk("ovf_neg", (obs_q.size() > 2) ? obs_q[2] : 16'hDEAD, 16'h7FFF);
        chk("ovf_sat_flag", sat_flag, 1'b0);
`endif
        chk("ovf_exact_min", (obs_q.size() > 5) ? obs_q[5] : 16'hDEAD, 16'h8000);

        // Reset after three outputs, then a clean frame from address 0.
        set_random();
        frame(0, 1'b0, 3, 1'b0, 1'b0);
        set_basic();
        frame(0, 1'b0, 0, 1'b0, 1'b0);
        chk("post_reset_last", (obs_q.size() > 5) ? obs_q[5] : 16'hDEAD, 16'd100);

        // Start pulsed mid-frame must be ignored.
        set_random();
        frame(3, 1'b1, 0, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            set_random();
            frame(3, 1'b0, 0, (f == 5), (f == 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
